// File: rtl/cpu_trace_monitor_if.sv
// cpu_trace_monitor_if: CPU observation, capture window, readout and status signals of the trace monitor
interface cpu_trace_monitor_if #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16
);
  logic [XLEN-1:0] pc, dmem_addr, dmem_wdata, filt_lo, filt_hi;
  logic dmem_we, rd_en, rd_valid, overflow;
  logic [2*XLEN-1:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  logic [1:0] state;
  logic [31:0] cycles;
  modport master(
    output pc, dmem_we, dmem_addr, dmem_wdata, filt_lo, filt_hi, rd_en,
    input rd_data, rd_valid, count, overflow, state, cycles
  );
  modport slave(
    input pc, dmem_we, dmem_addr, dmem_wdata, filt_lo, filt_hi, rd_en,
    output rd_data, rd_valid, count, overflow, state, cycles
  );
endinterface

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: run-control FSM (halt on stable PC / watchdog) plus a circular trace of filtered memory writes
module cpu_trace_monitor #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT = 500
) (
  input logic clk,
  input logic rst,
  cpu_trace_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, RUN, HALT, TMO} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc_q;
  logic [SW-1:0] stable;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [31:0] cycles;
  logic overflow, rd_valid;
  logic [2*XLEN-1:0] rd_data;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic same, full, push, pop, halt_hit, tmo_hit;
  always_comb begin
    same = bus.pc == pc_q;
    full = cnt == (AW+1)'(DEPTH);
    push = state == RUN && bus.dmem_we && bus.filt_lo <= bus.dmem_addr && bus.dmem_addr <= bus.filt_hi;
    pop = bus.rd_en && cnt != '0;
    halt_hit = same && stable == SW'(HALT_CYCLES - 1);
    tmo_hit = cycles == 32'(TIMEOUT - 1);
    state_n = state == IDLE ? RUN : state != RUN ? state : halt_hit ? HALT : tmo_hit ? TMO : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc_q <= '0;
      stable <= '0;
      cycles <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      pc_q <= bus.pc;
      stable <= state == RUN && same ? stable + 1'b1 : '0;
      cycles <= state == RUN && state_n == RUN && cycles != '1 ? cycles + 32'd1 : cycles;
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // A push into a full buffer without a pop evicts the oldest entry
      if (pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      cnt <= push && !pop && !full ? cnt + 1'b1 : pop && !push ? cnt - 1'b1 : cnt;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.dmem_addr, bus.dmem_wdata};
  assign bus.state = state;
  assign bus.count = cnt;
  assign bus.cycles = cycles;
  assign bus.overflow = overflow;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data = rd_data;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed plus randomized checking of cpu_trace_monitor against a queue-based model
module tb_cpu_trace_monitor;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int HALT = 4;
  localparam int TIMEOUT = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [31:0] pcc = '0;
  cpu_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();
  cpu_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .HALT_CYCLES(HALT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // Reference model: a queue of entries and run-control rules evaluated from pre-edge values
  logic [63:0] m_q[$];
  int m_state = 0;
  int m_streak = 0;
  logic [31:0] m_cycles = '0;
  logic [31:0] m_prev_pc = '0;
  logic m_ovf = 1'b0;
  logic m_valid = 1'b0;
  logic [63:0] m_data = '0;
  bit m_cap;
  always @(posedge clk) begin
    if (!rst) begin
      m_state = 0;
      m_streak = 0;
      m_cycles = '0;
      m_prev_pc = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_valid = 1'b0;
      m_data = '0;
    end else begin
      m_cap = m_state == 1 && bus.dmem_we && bus.filt_lo <= bus.dmem_addr && bus.dmem_addr <= bus.filt_hi;
      m_streak = (m_state == 1 && bus.pc == m_prev_pc) ? m_streak + 1 : 0;
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (m_streak == HALT) m_state = 2;
        else if (m_cycles == 32'(TIMEOUT - 1)) m_state = 3;
        else if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
      end
      m_valid = bus.rd_en && m_q.size() > 0;
      if (m_valid) m_data = m_q.pop_front();
      if (m_cap) begin
        m_q.push_back({bus.dmem_addr, bus.dmem_wdata});
        if (m_q.size() > DEPTH) begin
          m_q.delete(0);
          m_ovf = 1'b1;
        end
      end
      m_prev_pc = bus.pc;
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("m.state", 64'(bus.state), 64'(m_state));
    check("m.count", 64'(bus.count), 64'(m_q.size()));
    check("m.overflow", 64'(bus.overflow), 64'(m_ovf));
    check("m.cycles", 64'(bus.cycles), 64'(m_cycles));
    check("m.rd_valid", 64'(bus.rd_valid), 64'(m_valid));
    check("m.rd_data", bus.rd_data, m_data);
  end
  task automatic step(input logic [31:0] pcv, input logic we, input logic [31:0] addr, input logic [31:0] data, input logic rd);
    bus.pc = pcv;
    bus.dmem_we = we;
    bus.dmem_addr = addr;
    bus.dmem_wdata = data;
    bus.rd_en = rd;
    @(negedge clk);
  endtask
  task automatic go(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic rd);
    pcc = pcc + 32'd4;
    step(pcc, we, addr, data, rd);
  endtask
  task automatic restart(input logic [31:0] lo, input logic [31:0] hi);
    bus.filt_lo = lo;
    bus.filt_hi = hi;
    rst = 1'b0;
    step(32'h0, 1'b1, 32'h104, 32'hDEAD, 1'b0);
    step(32'h0, 1'b1, 32'h104, 32'hBEEF, 1'b1);
    rst = 1'b1;
  endtask
  initial begin
    bus.pc = '0;
    bus.dmem_we = 1'b0;
    bus.dmem_addr = '0;
    bus.dmem_wdata = '0;
    bus.rd_en = 1'b0;
    bus.filt_lo = '0;
    bus.filt_hi = '0;
    @(negedge clk);
    chk_en = 1'b1;
    // Reset and filtered capture
    restart(32'h100, 32'h110);
    check("reset.state", 64'(bus.state), 64'd0);
    check("reset.count", 64'(bus.count), 64'd0);
    check("reset.rd_valid", 64'(bus.rd_valid), 64'd0);
    go(1'b0, 32'h0, 32'h0, 1'b0);
    check("release.state", 64'(bus.state), 64'd1);
    go(1'b1, 32'h0FC, 32'd4, 1'b0);
    go(1'b1, 32'h100, 32'd5, 1'b0);
    go(1'b1, 32'h110, 32'd3, 1'b0);
    go(1'b1, 32'h114, 32'd1, 1'b0);
    check("filt.count", 64'(bus.count), 64'd2);
    go(1'b0, 32'h0, 32'h0, 1'b1);
    check("filt.pop1.valid", 64'(bus.rd_valid), 64'd1);
    check("filt.pop1.data", bus.rd_data, 64'h0000_0100_0000_0005);
    go(1'b0, 32'h0, 32'h0, 1'b0);
    check("filt.pulse", 64'(bus.rd_valid), 64'd0);
    go(1'b0, 32'h0, 32'h0, 1'b1);
    check("filt.pop2.data", bus.rd_data, 64'h0000_0110_0000_0003);
    go(1'b0, 32'h0, 32'h0, 1'b1);
    check("filt.empty_pop", 64'(bus.rd_valid), 64'd0);
    check("filt.hold_data", bus.rd_data, 64'h0000_0110_0000_0003);
    // Wrap and overflow
    restart(32'h100, 32'h110);
    go(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 6; i++) go(1'b1, 32'h108, 32'(i), 1'b0);
    check("wrap.count", 64'(bus.count), 64'd4);
    check("wrap.overflow", 64'(bus.overflow), 64'd1);
    for (int i = 3; i <= 6; i++) begin
      go(1'b0, 32'h0, 32'h0, 1'b1);
      check("wrap.pop", bus.rd_data, {32'h108, 32'(i)});
    end
    check("wrap.drained", 64'(bus.count), 64'd0);
    // Simultaneous push and pop, full then empty
    restart(32'h100, 32'h110);
    go(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) go(1'b1, 32'h104, 32'(i), 1'b0);
    check("full.overflow0", 64'(bus.overflow), 64'd0);
    go(1'b1, 32'h104, 32'd9, 1'b1);
    check("full.pp.data", bus.rd_data, 64'h0000_0104_0000_0001);
    check("full.pp.count", 64'(bus.count), 64'd4);
    check("full.pp.overflow", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 4; i++) go(1'b0, 32'h0, 32'h0, 1'b1);
    check("full.last", bus.rd_data, 64'h0000_0104_0000_0009);
    go(1'b1, 32'h104, 32'hA, 1'b1);
    check("empty.pp.count", 64'(bus.count), 64'd1);
    check("empty.pp.valid", 64'(bus.rd_valid), 64'd0);
    // Halt detection, including capture on the transition edge
    restart(32'h100, 32'h110);
    step(32'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    step(32'h04, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(32'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    check("halt.before", 64'(bus.state), 64'd1);
    step(32'h40, 1'b1, 32'h100, 32'h77, 1'b0);
    check("halt.state", 64'(bus.state), 64'd2);
    check("halt.last_capture", 64'(bus.count), 64'd1);
    check("halt.cycles", 64'(bus.cycles), 64'd5);
    step(32'h40, 1'b1, 32'h100, 32'h78, 1'b0);
    check("halt.no_capture", 64'(bus.count), 64'd1);
    check("halt.frozen", 64'(bus.cycles), 64'd5);
    // Watchdog timeout
    restart(32'h100, 32'h110);
    go(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 19; i++) go(1'b0, 32'h0, 32'h0, 1'b0);
    check("tmo.before", 64'(bus.state), 64'd1);
    go(1'b0, 32'h0, 32'h0, 1'b0);
    check("tmo.state", 64'(bus.state), 64'd3);
    check("tmo.cycles", 64'(bus.cycles), 64'd19);
    // Halt and timeout on the same edge
    restart(32'h100, 32'h110);
    step(32'h1000, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 16; i++) step(32'(4 * i), 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(32'd64, 1'b0, 32'h0, 32'h0, 1'b0);
    check("tie.state", 64'(bus.state), 64'd2);
    check("tie.cycles", 64'(bus.cycles), 64'd19);
    // Randomized traffic, occasional mid-run resets, windows that may be empty
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) == 0) restart(32'h0, 32'hFFFF_FFFF);
      else restart(32'($urandom_range(0, 63)), 32'($urandom_range(0, 63)));
      for (int c = 0, len = $urandom_range(5, 40); c < len; c++) begin
        rst = $urandom_range(0, 99) != 0;
        if ($urandom_range(0, 2) != 0) pcc = 32'($urandom_range(0, 7) * 4);
        step(pcc, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 2) == 0));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
